// File: rtl/glyph_pkg.sv
// Shared constants for the glyph pixel streamer: default glyph geometry, FSM encoding
// and the width of the scale field.
package glyph_pkg;

  localparam int unsigned GlyphWDefault    = 8;
  localparam int unsigned GlyphHDefault    = 16;
  localparam int unsigned NumGlyphsDefault = 16;

  localparam int unsigned ScaleW = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StFetch  = 2'd1;
  localparam state_t StStream = 2'd2;

endpackage

// File: rtl/glyph_font_rom.sv
// Synchronous 1-bit font ROM with registered output (1-cycle latency).
// Bit address = code*GlyphW*GlyphH + row*GlyphW + col; the bitmaps are the team 8x16 digit/hex font.
module glyph_font_rom #(
  parameter int unsigned GlyphW    = 8,
  parameter int unsigned GlyphH    = 16,
  parameter int unsigned NumGlyphs = 16,
  parameter int unsigned Depth     = NumGlyphs * GlyphW * GlyphH,
  parameter int unsigned AddrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [AddrW-1:0] addr_i,
  output logic             data_o
);

  // One glyph as 16 row bytes, row 0 in the top byte, leftmost pixel in each byte's MSB.
  function automatic logic [127:0] glyph_bitmap(input int unsigned gi);
    logic [127:0] g;
    case (gi)
      0:       g = 128'h00000038_44444C54_64444438_00000000;
      1:       g = 128'h00000010_30501010_1010107C_00000000;
      2:       g = 128'h00000038_44040408_1020407C_00000000;
      3:       g = 128'h00000038_44040418_04044438_00000000;
      4:       g = 128'h00000008_18284848_7C080808_00000000;
      5:       g = 128'h0000007C_40407804_04044438_00000000;
      6:       g = 128'h00000038_44404078_44444438_00000000;
      7:       g = 128'h0000007C_04040810_10202020_00000000;
      8:       g = 128'h00000038_44444438_44444438_00000000;
      9:       g = 128'h00000038_4444443C_04040830_00000000;
      10:      g = 128'h00000010_28444444_7C444444_00000000;
      11:      g = 128'h00000078_44444478_44444478_00000000;
      12:      g = 128'h00000038_44404040_40404438_00000000;
      13:      g = 128'h00000070_48444444_44444870_00000000;
      14:      g = 128'h0000007C_40404078_4040407C_00000000;
      15:      g = 128'h0000007C_40404078_40404040_00000000;
      default: g = '0;
    endcase
    return g;
  endfunction

  function automatic logic [Depth-1:0] build_font();
    logic [Depth-1:0] bits;
    logic [127:0]     g;
    logic [AddrW-1:0] idx;
    logic [6:0]       gb;
    bits = '0;
    for (int unsigned gi = 0; gi < NumGlyphs; gi++) begin
      g = glyph_bitmap(gi);
      for (int unsigned r = 0; r < GlyphH; r++) begin
        for (int unsigned c = 0; c < GlyphW; c++) begin
          // Area outside the 8x16 source bitmap stays blank for larger glyph cells.
          if (r < 16 && c < 8) begin
            idx       = AddrW'(gi * GlyphW * GlyphH + r * GlyphW + c);
            gb        = 7'(127 - 8 * r - c);
            bits[idx] = g[gb];
          end
        end
      end
    end
    return bits;
  endfunction

  localparam logic [Depth-1:0] Font = build_font();

  logic data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= Font[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/glyph_pixel_streamer.sv
// Renders one glyph per request as a row-major pixel stream with optional integer upscaling.
// Define GLYPH_SCALE_EN to honour req_scale; otherwise the scale is fixed at 1.
module glyph_pixel_streamer
  import glyph_pkg::*;
#(
  parameter int unsigned GLYPH_W    = GlyphWDefault,
  parameter int unsigned GLYPH_H    = GlyphHDefault,
  parameter int unsigned NUM_GLYPHS = NumGlyphsDefault,
  parameter int unsigned COLOR_W    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [$clog2(NUM_GLYPHS)-1:0] req_code,
  input  logic [COLOR_W-1:0]            req_fg,
  input  logic [COLOR_W-1:0]            req_bg,
  input  logic [ScaleW-1:0]             req_scale,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [COLOR_W-1:0]            pix_data,
  output logic                          pix_eol,
  output logic                          pix_last,
  output logic                          busy
);

  localparam int unsigned CodeW = $clog2(NUM_GLYPHS);
  localparam int unsigned ColW  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned RowW  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned Depth = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [ColW-1:0] ColMax = ColW'(GLYPH_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(GLYPH_H - 1);

  state_t             state_q, state_d;
  logic [CodeW-1:0]   code_q, code_d;
  logic               code_ok_q, code_ok_d;
  logic [COLOR_W-1:0] fg_q, fg_d;
  logic [COLOR_W-1:0] bg_q, bg_d;
  logic [ColW-1:0]    col_q, col_d, col_nxt;
  logic [RowW-1:0]    row_q, row_d, row_nxt;

  logic req_fire, pix_fire;
  logic col_sub_wrap, row_sub_wrap, col_wrap, row_wrap;
  logic rom_en, rom_bit;
  logic [AddrW-1:0] rom_addr;

`ifdef GLYPH_SCALE_EN
  logic [ScaleW-1:0] scale_q, scale_d;
  logic [ScaleW-1:0] col_sub_q, col_sub_d, col_sub_nxt;
  logic [ScaleW-1:0] row_sub_q, row_sub_d, row_sub_nxt;

  assign col_sub_wrap = (col_sub_q == scale_q);
  assign row_sub_wrap = (row_sub_q == scale_q);
`else
  logic unused_scale;

  assign unused_scale = ^req_scale;
  assign col_sub_wrap = 1'b1;
  assign row_sub_wrap = 1'b1;
`endif

  function automatic logic [AddrW-1:0] bit_addr(input logic [CodeW-1:0] code,
                                                input logic [RowW-1:0]  row,
                                                input logic [ColW-1:0]  col);
    return AddrW'(code) * AddrW'(GLYPH_W * GLYPH_H) + AddrW'(row) * AddrW'(GLYPH_W)
           + AddrW'(col);
  endfunction

  assign req_ready = (state_q == StIdle) && !reset;
  assign req_fire  = req_valid && req_ready;
  assign pix_valid = (state_q == StStream);
  assign pix_fire  = pix_valid && pix_ready;
  assign busy      = (state_q != StIdle);

  assign col_wrap = col_sub_wrap && (col_q == ColMax);
  assign row_wrap = row_sub_wrap && (row_q == RowMax);

  assign pix_eol  = pix_valid && col_wrap;
  assign pix_last = pix_valid && col_wrap && row_wrap;
  assign pix_data = !pix_valid ? '0 : (rom_bit && code_ok_q) ? fg_q : bg_q;

  // Coordinates of the pixel after the current one; also the ROM prefetch address.
  always_comb begin
    col_nxt = col_q;
    row_nxt = row_q;
`ifdef GLYPH_SCALE_EN
    col_sub_nxt = col_sub_q + 1'b1;
    row_sub_nxt = row_sub_q;
`endif
    if (col_sub_wrap) begin
`ifdef GLYPH_SCALE_EN
      col_sub_nxt = '0;
`endif
      col_nxt = col_wrap ? '0 : col_q + 1'b1;
    end
    if (col_wrap) begin
      if (row_sub_wrap) begin
`ifdef GLYPH_SCALE_EN
        row_sub_nxt = '0;
`endif
        row_nxt = row_wrap ? '0 : row_q + 1'b1;
      end else begin
`ifdef GLYPH_SCALE_EN
        row_sub_nxt = row_sub_q + 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    code_ok_d = code_ok_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    col_d     = col_q;
    row_d     = row_q;
`ifdef GLYPH_SCALE_EN
    scale_d   = scale_q;
    col_sub_d = col_sub_q;
    row_sub_d = row_sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          state_d   = StFetch;
          code_d    = req_code;
          code_ok_d = (32'(req_code) < NUM_GLYPHS);
          fg_d      = req_fg;
          bg_d      = req_bg;
          col_d     = '0;
          row_d     = '0;
`ifdef GLYPH_SCALE_EN
          scale_d   = req_scale;
          col_sub_d = '0;
          row_sub_d = '0;
`endif
        end
      end
      StFetch: begin
        state_d = StStream;
      end
      StStream: begin
        if (pix_fire) begin
          col_d = col_nxt;
          row_d = row_nxt;
`ifdef GLYPH_SCALE_EN
          col_sub_d = col_sub_nxt;
          row_sub_d = row_sub_nxt;
`endif
          if (pix_last) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Out-of-range codes never touch the ROM; their pixels are forced to background.
  always_comb begin
    rom_en   = 1'b0;
    rom_addr = bit_addr(code_q, row_q, col_q);
    if (state_q == StFetch) begin
      rom_en = code_ok_q;
    end else if (state_q == StStream && pix_ready) begin
      rom_en   = code_ok_q;
      rom_addr = bit_addr(code_q, row_nxt, col_nxt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      code_q    <= '0;
      code_ok_q <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
`ifdef GLYPH_SCALE_EN
      scale_q   <= '0;
      col_sub_q <= '0;
      row_sub_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      code_ok_q <= code_ok_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      col_q     <= col_d;
      row_q     <= row_d;
`ifdef GLYPH_SCALE_EN
      scale_q   <= scale_d;
      col_sub_q <= col_sub_d;
      row_sub_q <= row_sub_d;
`endif
    end
  end

  glyph_font_rom #(
    .GlyphW   (GLYPH_W),
    .GlyphH   (GLYPH_H),
    .NumGlyphs(NUM_GLYPHS),
    .AddrW    (AddrW)
  ) u_font_rom (
    .clk_i (clock),
    .en_i  (rom_en),
    .addr_i(rom_addr),
    .data_o(rom_bit)
  );

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Directed bench for glyph_pixel_streamer: expected pixel frames are queued when a request
// is accepted and compared as pixels are transferred.
module tb_glyph_pixel_streamer;

  localparam int unsigned GW    = 8;
  localparam int unsigned GH    = 16;
  localparam int unsigned NG    = 20;  // wide enough code port to present out-of-range codes
  localparam int unsigned CW    = 16;
  localparam int unsigned CodeW = $clog2(NG);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CodeW-1:0]  req_code = '0;
  logic [CW-1:0]     req_fg = '0;
  logic [CW-1:0]     req_bg = '0;
  logic [1:0]        req_scale = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [CW-1:0]     pix_data;
  logic              pix_eol;
  logic              pix_last;
  logic              busy;

  always #5 clock = ~clock;

  glyph_pixel_streamer #(
    .GLYPH_W   (GW),
    .GLYPH_H   (GH),
    .NUM_GLYPHS(NG),
    .COLOR_W   (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_code (req_code),
    .req_fg   (req_fg),
    .req_bg   (req_bg),
    .req_scale(req_scale),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_eol  (pix_eol),
    .pix_last (pix_last),
    .busy     (busy)
  );

  typedef struct packed {
    logic [CW-1:0] data;
    logic          eol;
    logic          last;
  } pix_t;

  typedef struct packed {
    logic [CodeW-1:0] code;
    logic [CW-1:0]    fg;
    logic [CW-1:0]    bg;
    logic [1:0]       scale;
  } req_t;

  pix_t exp_q[$];
  req_t req_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frames = 0;
  int   pix_idx = 0;
  int   t_req = -100;
  int   t_last = -100;
  bit   ready_toggle = 1'b0;
  bit   await_first = 1'b0;
  bit   gap_pending = 1'b0;
  bit   after_last = 1'b0;
  bit   fetch_chk = 1'b0;
  bit   stalled = 1'b0;
  pix_t held;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference bitmaps of the glyphs exercised here (row 0 top byte, leftmost pixel MSB).
  function automatic logic font_bit(input int code, input int row, input int col);
    logic [127:0] g;
    case (code)
      1:       g = 128'h00000010_30501010_1010107C_00000000;
      2:       g = 128'h00000038_44040408_1020407C_00000000;
      9:       g = 128'h00000038_4444443C_04040830_00000000;
      default: g = '0;
    endcase
    return g[7'(127 - 8 * row - col)];
  endfunction

  task automatic push_frame(input req_t r);
    int   s;
    pix_t p;
    logic b;
    s = 1;
`ifdef GLYPH_SCALE_EN
    s = int'(r.scale) + 1;
`endif
    for (int y = 0; y < int'(GH) * s; y++) begin
      for (int x = 0; x < int'(GW) * s; x++) begin
        b      = (int'(r.code) < int'(NG)) && font_bit(int'(r.code), y / s, x / s);
        p.data = b ? r.fg : r.bg;
        p.eol  = (x == int'(GW) * s - 1);
        p.last = p.eol && (y == int'(GH) * s - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input req_t r);
    req_valid = 1'b1;
    req_code  = r.code;
    req_fg    = r.fg;
    req_bg    = r.bg;
    req_scale = r.scale;
  endtask

  task automatic submit(input logic [CodeW-1:0] code, input logic [CW-1:0] fg,
                        input logic [CW-1:0] bg, input logic [1:0] scale);
    req_t r;
    r = '{code: code, fg: fg, bg: bg, scale: scale};
    req_q.push_back(r);
    if (!req_valid) drive_req(r);
  endtask

  // One cycle at the sample point: handle both ports, then advance the clock.
  task automatic service();
    pix_t obs;
    pix_t e;
    bit   fire;
    bit   was_after_last;
    fire           = req_valid && req_ready;
    was_after_last = after_last;
    obs            = {pix_data, pix_eol, pix_last};
    if (fetch_chk) begin
      check("fetch_state", {61'd0, busy, pix_valid, req_ready}, 64'b100);
      fetch_chk = 1'b0;
    end
    if (after_last) begin
      check("ready_after_last", {61'd0, req_ready, busy, pix_valid}, 64'b100);
      after_last = 1'b0;
    end
    if (stalled) check("stall_hold", 64'({pix_valid, obs}), 64'({1'b1, held}));
    stalled = 1'b0;
    if (fire) begin
      push_frame(req_q.pop_front());
      t_req       = cyc;
      await_first = 1'b1;
      fetch_chk   = 1'b1;
      gap_pending = was_after_last;
    end
    pix_ready = ready_toggle ? rdy_pat[2'(cyc % 4)] : 1'b1;
    if (pix_valid && await_first) begin
      check("first_latency", 64'(cyc - t_req), 64'd2);
      if (gap_pending) check("b2b_gap", 64'(cyc - t_last), 64'd3);
      await_first = 1'b0;
      gap_pending = 1'b0;
    end
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", 64'(obs), 64'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pixel%0d", pix_idx), 64'(obs), 64'(e));
      end
      pix_idx++;
      if (pix_last) begin
        frames++;
        pix_idx    = 0;
        t_last     = cyc;
        after_last = 1'b1;
      end
    end else if (pix_valid) begin
      stalled = 1'b1;
      held    = obs;
    end
    tick();
    if (fire) begin
      if (req_q.size() > 0) begin
        drive_req(req_q[0]);
      end else begin
        // Scramble the request inputs: the glyph in flight must not follow them.
        req_valid = 1'b0;
        req_code  = CodeW'(7);
        req_fg    = 16'h5A5A;
        req_bg    = 16'hA5A5;
        req_scale = 2'd3;
      end
    end
  endtask

  task automatic run(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || req_q.size() > 0 || after_last) && n < 5000) begin
      service();
      n++;
    end
    check({tag, "_complete"}, 64'(exp_q.size() + req_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outs", {38'd0, req_ready, pix_valid, pix_eol, pix_last, busy, pix_data},
          64'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {61'd0, req_ready, busy, pix_valid}, 64'b100);

    // Code 9 at scale 1, sink always ready.
    submit(CodeW'(9), 16'hFFFF, 16'h0000, 2'd0);
    run("s1");

    // Code 9 with req_scale=1: 2x when scaling is built in, 1x otherwise.
    submit(CodeW'(9), 16'hF800, 16'h001F, 2'd1);
    run("s2");

    // Sink stalls in a 1,0,0,1 pattern.
    ready_toggle = 1'b1;
    submit(CodeW'(9), 16'hFFFF, 16'h0000, 2'd0);
    run("stall");
    ready_toggle = 1'b0;

    // Out-of-range code renders background only.
    submit(CodeW'(20), 16'h07E0, 16'hABCD, 2'd2);
    run("badcode");

    // Reset while pixel 50 is on the port.
    submit(CodeW'(2), 16'h1234, 16'h4321, 2'd0);
    n = 0;
    while (!(pix_valid && pix_idx == 50) && n < 500) begin
      service();
      n++;
    end
    check("abort_reached", 64'(pix_idx), 64'd50);
    reset = 1'b1;
    tick();
    check("abort_outs", {38'd0, req_ready, pix_valid, pix_eol, pix_last, busy, pix_data},
          64'd0);
    exp_q.delete();
    pix_idx     = 0;
    stalled     = 1'b0;
    await_first = 1'b0;
    fetch_chk   = 1'b0;
    reset       = 1'b0;
    tick();
    check("ready_after_abort", {61'd0, req_ready, busy, pix_valid}, 64'b100);
    submit(CodeW'(1), 16'hFFFF, 16'h0000, 2'd0);
    run("post_abort");

    // Back-to-back requests: second frame follows after two idle cycles.
    submit(CodeW'(1), 16'hC0DE, 16'h0101, 2'd0);
    submit(CodeW'(2), 16'hBEEF, 16'h0202, 2'd0);
    run("b2b");

    check("frames_total", 64'(frames), 64'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
